// File: rtl/match_controller.sv
// Pong match sequencer: serve timing, scoring, winner detection and ball hold/launch control.
// Optional WIN_BY_TWO_EN: winner needs WIN_SCORE and a lead of two; overflowing scores shift both down.
module match_controller #(
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned SERVE_DELAY = 120,
    parameter bit          SERVE_FIRST = 1'b0,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned DELAY_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               enable,
    input  logic               new_match,
    input  logic               goal_p1,
    input  logic               goal_p2,
    output logic               ball_reset,
    output logic               ball_serve,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               match_over,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [DELAY_W-1:0] DELAY_INIT = DELAY_W'(SERVE_DELAY);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_RALLY      = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic               dir_q, dir_d;
    logic               ball_reset_q, ball_reset_d;
    logic               ball_serve_q, ball_serve_d;
    logic               match_over_q, match_over_d;
    logic [1:0]         winner_q, winner_d;

`ifdef WIN_BY_TWO_EN
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    function automatic logic p_wins(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        return (a >= WIN_S) && ({1'b0, a} >= ({1'b0, b} + (SCORE_W+1)'(2)));
    endfunction

    // Decrement-both-then-increment collapses to: scorer holds at max, opponent drops by one
    function automatic logic [2*SCORE_W-1:0] bump(input logic [SCORE_W-1:0] win_s,
                                                  input logic [SCORE_W-1:0] lose_s);
        if (win_s == SCORE_MAX) return {win_s, lose_s - SCORE_W'(1)};
        return {win_s + SCORE_W'(1), lose_s};
    endfunction
`else
    function automatic logic p_wins(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        return (a >= WIN_S) && (a >= b);
    endfunction

    function automatic logic [2*SCORE_W-1:0] bump(input logic [SCORE_W-1:0] win_s,
                                                  input logic [SCORE_W-1:0] lose_s);
        if (win_s >= WIN_S) return {win_s, lose_s};
        return {win_s + SCORE_W'(1), lose_s};
    endfunction
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            dir_q        <= SERVE_FIRST;
            ball_reset_q <= 1'b1;
            ball_serve_q <= 1'b0;
            match_over_q <= 1'b0;
            winner_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            dir_q        <= dir_d;
            ball_reset_q <= ball_reset_d;
            ball_serve_q <= ball_serve_d;
            match_over_q <= match_over_d;
            winner_q     <= winner_d;
        end
    end

    // Next state, serve countdown and scoring
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dir_d   = dir_q;
        if (new_match) begin
            state_d = ST_SERVE_WAIT;
            cnt_d   = DELAY_INIT;
            s1_d    = '0;
            s2_d    = '0;
            dir_d   = SERVE_FIRST;
        end else begin
            case (state_q)
                ST_SERVE_WAIT: begin
                    if (tick && enable) begin
                        if (cnt_q <= DELAY_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_RALLY;
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                end
                ST_RALLY: begin
                    // The point loser receives the next serve; simultaneous goals replay the point
                    if (goal_p1 && !goal_p2) begin
                        {s1_d, s2_d} = bump(s1_q, s2_q);
                        dir_d        = 1'b1;
                        state_d      = ST_POINT;
                    end else if (goal_p2 && !goal_p1) begin
                        {s2_d, s1_d} = bump(s2_q, s1_q);
                        dir_d        = 1'b0;
                        state_d      = ST_POINT;
                    end else if (goal_p1 && goal_p2) begin
                        state_d = ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (p_wins(s1_q, s2_q) || p_wins(s2_q, s1_q)) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        cnt_d   = DELAY_INIT;
                        state_d = ST_SERVE_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        ball_reset_d = (state_d != ST_RALLY);
        ball_serve_d = (state_q == ST_SERVE_WAIT) && (state_d == ST_RALLY);
        match_over_d = (state_d == ST_GAME_OVER);
        winner_d     = 2'b00;
        if (state_d == ST_GAME_OVER) begin
            winner_d = p_wins(s1_d, s2_d) ? 2'b01 : 2'b10;
        end
    end

    assign ball_reset = ball_reset_q;
    assign ball_serve = ball_serve_q;
    assign serve_dir  = dir_q;
    assign score_p1   = s1_q;
    assign score_p2   = s2_q;
    assign match_over = match_over_q;
    assign winner     = winner_q;
    assign state      = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: a point-level reference model predicts every cycle's outputs.
module tb_match_controller;

    localparam int unsigned SCORE_W     = 4;
    localparam int unsigned DELAY_W     = 8;
    localparam int unsigned SERVE_DELAY = 3;
`ifdef WIN_BY_TWO_EN
    localparam int unsigned WIN_SCORE   = 3;
`else
    localparam int unsigned WIN_SCORE   = 9;
`endif
    localparam bit          SERVE_FIRST = 1'b0;
    localparam int          MAXS        = (1 << SCORE_W) - 1;

    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_RALLY = 2, PH_POINT = 3, PH_OVER = 4;

    logic               clk = 1'b0;
    logic               reset, tick, enable, new_match, goal_p1, goal_p2;
    logic               ball_reset, ball_serve, serve_dir, match_over;
    logic [SCORE_W-1:0] score_p1, score_p2;
    logic [1:0]         winner;
    logic [2:0]         state;

    match_controller #(
        .WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY), .SERVE_FIRST(SERVE_FIRST),
        .SCORE_W(SCORE_W), .DELAY_W(DELAY_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .new_match(new_match),
        .goal_p1(goal_p1), .goal_p2(goal_p2), .ball_reset(ball_reset), .ball_serve(ball_serve),
        .serve_dir(serve_dir), .score_p1(score_p1), .score_p2(score_p2),
        .match_over(match_over), .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               br;
        logic               bs;
        logic               dir;
        logic [SCORE_W-1:0] s1;
        logic [SCORE_W-1:0] s2;
        logic               mo;
        logic [1:0]         win;
        logic [2:0]         st;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   prev_r  = 1'b0;

    // Reference model: match phase, scores, remaining serve ticks, next serve direction
    int m_phase, m_s1, m_s2, m_left;
    bit m_dir, m_serve;

    function automatic int decided(input int a, input int b);
`ifdef WIN_BY_TWO_EN
        if (a >= WIN_SCORE && a - b >= 2) return 1;
        if (b >= WIN_SCORE && b - a >= 2) return 2;
`else
        if (a >= WIN_SCORE) return 1;
        if (b >= WIN_SCORE) return 2;
`endif
        return 0;
    endfunction

    function automatic obs_t predicted();
        obs_t o;
        o.br  = (m_phase != PH_RALLY);
        o.bs  = m_serve;
        o.dir = m_dir;
        o.s1  = SCORE_W'(m_s1);
        o.s2  = SCORE_W'(m_s2);
        o.mo  = (m_phase == PH_OVER);
        o.win = (m_phase == PH_OVER) ? 2'(decided(m_s1, m_s2)) : 2'b00;
        o.st  = 3'(m_phase);
        return o;
    endfunction

    function automatic obs_t observed();
        return {ball_reset, ball_serve, serve_dir, score_p1, score_p2, match_over, winner, state};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_s1 = 0; m_s2 = 0; m_left = 0; m_dir = SERVE_FIRST; m_serve = 1'b0;
    endtask

    task automatic award(input int who);
        int w, l;
        w = (who == 1) ? m_s1 : m_s2;
        l = (who == 1) ? m_s2 : m_s1;
`ifdef WIN_BY_TWO_EN
        if (w == MAXS) begin w--; l--; end
`endif
        w++;
        if (who == 1) begin m_s1 = w; m_s2 = l; end
        else begin m_s2 = w; m_s1 = l; end
    endtask

    task automatic model_step(input bit nm, input bit t, input bit en, input bit g1, input bit g2);
        m_serve = 1'b0;
        if (nm) begin
            m_phase = PH_WAIT; m_s1 = 0; m_s2 = 0; m_left = SERVE_DELAY; m_dir = SERVE_FIRST;
        end else if (m_phase == PH_WAIT) begin
            if (t && en) begin
                m_left--;
                if (m_left == 0) begin m_phase = PH_RALLY; m_serve = 1'b1; end
            end
        end else if (m_phase == PH_RALLY) begin
            if (g1 != g2) begin
                award(g1 ? 1 : 2);
                m_dir = g1;
            end
            if (g1 || g2) m_phase = PH_POINT;
        end else if (m_phase == PH_POINT) begin
            if (decided(m_s1, m_s2) != 0) m_phase = PH_OVER;
            else begin m_left = SERVE_DELAY; m_phase = PH_WAIT; end
        end
    endtask

    task automatic report(input string name, input obs_t a, input obs_t e);
        $display("FAIL %s t=%0t got br=%0b bs=%0b dir=%0b s1=%0d s2=%0d mo=%0b win=%b st=%0d want br=%0b bs=%0b dir=%0b s1=%0d s2=%0d mo=%0b win=%b st=%0d",
                 name, $time, a.br, a.bs, a.dir, a.s1, a.s2, a.mo, a.win, a.st,
                 e.br, e.bs, e.dir, e.s1, e.s2, e.mo, e.win, e.st);
    endtask

    // One clock of stimulus; the predicted post-edge outputs go to the scoreboard
    task automatic step(input bit r, input bit nm, input bit t, input bit en, input bit g1, input bit g2);
        obs_t a, e;
        @(negedge clk);
        reset = r; new_match = nm; tick = t; enable = en; goal_p1 = g1; goal_p2 = g2;
        if (!r) begin
            model_reset();
            if (prev_r) begin
                #1;
                a = observed();
                e = predicted();
                n_tests++;
                if (a !== e) begin n_fail++; report("async_reset", a, e); end
            end
        end else begin
            model_step(nm, t, en, g1, g2);
        end
        exp_q.push_back(predicted());
        prev_r = r;
        cyc++;
    endtask

    task automatic play(input bit g1, input bit g2);
        step(1'b1, 1'b0, (cyc % 4) == 0, 1'b1, g1, g2);
    endtask

    task automatic run_to_play(input int bound);
        int k;
        k = 0;
        while (m_phase != PH_RALLY && m_phase != PH_OVER && k < bound) begin
            play(1'b0, 1'b0);
            k++;
        end
        if (m_phase != PH_RALLY && m_phase != PH_OVER) begin
            n_fail++;
            $display("FAIL serve_timeout t=%0t phase=%0d", $time, m_phase);
        end
    endtask

    // Monitor: compare DUT outputs each cycle against the oldest prediction
    obs_t mon_a, mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = observed();
                n_tests++;
                if (mon_a !== mon_e) begin n_fail++; report("outputs", mon_a, mon_e); end
            end
        end
    end

    initial begin
        reset = 1'b0; tick = 1'b0; enable = 1'b0; new_match = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
        model_reset();

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // First serve, then a long goal_p1 level that must count once
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_to_play(100);
        repeat (10) play(1'b1, 1'b0);
        run_to_play(100);

        // Simultaneous goals replay the point
        play(1'b1, 1'b1);
        run_to_play(100);

        // Player two scores until the match ends
        for (int k = 0; k < 40 && m_phase != PH_OVER; k++) begin
            play(1'b0, 1'b1);
            run_to_play(100);
        end
        repeat (5) play(1'b1, 1'b0);
        repeat (5) play(1'b0, 1'b1);

        // Pause during serve wait: counter frozen across 20 ticks
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) play(1'b0, 1'b0);
        repeat (80) step(1'b1, 1'b0, (cyc % 4) == 0, 1'b0, 1'b0, 1'b0);
        run_to_play(100);

        // Reset in the middle of a serve wait
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) play(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) play(1'b0, 1'b0);

`ifdef WIN_BY_TWO_EN
        // Deuce at 3-3, then two points for player one
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_to_play(100); play(1'b1, 1'b0);
            run_to_play(100); play(1'b0, 1'b1);
        end
        run_to_play(100); play(1'b1, 1'b0);
        run_to_play(100); play(1'b1, 1'b0);
        repeat (3) play(1'b0, 1'b0);
        n_tests++;
        if (match_over !== 1'b1 || winner !== 2'b01 || score_p1 !== SCORE_W'(5) || score_p2 !== SCORE_W'(3)) begin
            n_fail++;
            $display("FAIL win_by_two got mo=%0b win=%b s1=%0d s2=%0d want mo=1 win=01 s1=5 s2=3",
                     match_over, winner, score_p1, score_p2);
        end

        // Long deuce pushes scores to the top of the range
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 36; k++) begin
            run_to_play(100); play(1'b1, 1'b0);
            run_to_play(100); play(1'b0, 1'b1);
        end
`endif

        // Randomized play
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 1000) != 0, ($urandom % 400) == 0, ($urandom % 3) == 0,
                 ($urandom % 10) != 0, ($urandom % 12) == 0, ($urandom % 12) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences Pong rounds between the main menu FSM and the ball/paddle datapath.
- Consumes goal events from game logic and keeps both scores.
- Holds the ball at centre during a timed serve delay, then issues a serve pulse with direction.
- Declares the match winner and freezes play until a new match is requested.

Parameters:
- WIN_SCORE, 9: points needed to win (1..2^SCORE_W-1).
- SERVE_DELAY, 120: game ticks between point/new match and serve (1..2^DELAY_W-1).
- SERVE_FIRST, 0: serve direction of first rally (0 = toward left paddle, 1 = toward right).
- SCORE_W, 4: score width.
- DELAY_W, 8: delay counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  game-tick strobe, one clk cycle wide, synchronous to clk
- enable  in  1  play enabled; low = paused, all timing frozen
- new_match  in  1  pulse: clear scores, start serve sequence
- goal_p1  in  1  ball crossed right boundary, player one scores (level, sampled each clk)
- goal_p2  in  1  ball crossed left boundary, player two scores
- ball_reset  out  1  hold ball at centre, velocity zero
- ball_serve  out  1  one-clk pulse: launch ball
- serve_dir  out  1  launch direction, valid while ball_serve = 1
- score_p1  out  SCORE_W  player one score
- score_p2  out  SCORE_W  player two score
- match_over  out  1  winner decided
- winner  out  2  00 none, 01 player one, 10 player two
- state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (reset = 0, async): state IDLE; scores 0; delay counter 0; ball_reset = 1; ball_serve = 0; serve_dir = SERVE_FIRST; match_over = 0; winner = 00. Reset mid-operation aborts everything immediately.
- States: IDLE=0, SERVE_WAIT=1, RALLY=2, POINT=3, GAME_OVER=4.
- IDLE: ball_reset = 1. new_match goes to SERVE_WAIT.
- new_match in any state (highest priority after reset):
  - next cycle scores = 0, winner = 00, match_over = 0, serve_dir = SERVE_FIRST, counter = SERVE_DELAY, state SERVE_WAIT.
- SERVE_WAIT: ball_reset = 1.
  - Counter decrements on each cycle with tick & enable.
  - The tick that takes the counter from 1 to 0 causes, in the next cycle, ball_serve = 1 for exactly one clk, ball_reset = 0, state RALLY.
- RALLY: ball_reset = 0.
  - goal_p1 alone: score_p1 += 1, serve_dir = 1 (toward the loser), state POINT. Score visible the cycle after the goal is sampled.
  - goal_p2 alone: score_p2 += 1, serve_dir = 0, state POINT.
  - goal_p1 & goal_p2 in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
  - Goals are sampled regardless of enable; the datapath does not move while paused.
- POINT: lasts exactly one clk; ball_reset = 1.
  - If a score equals WIN_SCORE: GAME_OVER.
  - Otherwise: counter = SERVE_DELAY, SERVE_WAIT.
- GAME_OVER: ball_reset = 1, match_over = 1, winner set. Scores held; goals ignored. Only new_match or reset exits.
- Goals outside RALLY are ignored (no double counting while the goal level persists during POINT/SERVE_WAIT).
- Scores never exceed WIN_SCORE (no wrap).
- enable = 0 freezes the counter. State transitions triggered by goals or new_match still occur.
- All outputs are registered. No combinational path from input to output.

Optional Feature:
- Macro WIN_BY_TWO_EN.
- Defined: a player wins only when score ≥ WIN_SCORE and leads by ≥ 2.
  - If an increment would exceed 2^SCORE_W-1, both scores are instead decremented by 1 before the increment, so the lead is preserved and there is no overflow.
- Undefined: first to WIN_SCORE wins, as above.

Test Plan:
- Reset then new_match, SERVE_DELAY = 3, tick every 4 clk, enable = 1 → ball_serve single pulse after 3rd tick, serve_dir = 0, state RALLY, ball_reset 1→0 in the same cycle.
- In RALLY, goal_p1 held 10 clk → score_p1 = 1 exactly (not 10), serve_dir = 1, next serve after 3 ticks.
- goal_p1 and goal_p2 asserted in the same cycle → scores unchanged, POINT → SERVE_WAIT, re-serve with previous serve_dir.
- Drive score_p2 to WIN_SCORE = 9 → match_over = 1, winner = 10, further goals ignored; new_match → scores 0, winner 00, SERVE_WAIT.
- During SERVE_WAIT drop enable for 20 ticks → counter frozen, no serve; re-enable → serve after the remaining ticks. Assert reset mid-wait → immediate IDLE, all outputs at reset values.
- WIN_BY_TWO_EN, WIN_SCORE = 3: 3–3 then p1 scores → 4–3, no winner; p1 scores → 5–3, winner = 01.
